// File: rtl/cam_img_seq_ctrl.sv
// cam_img_seq_ctrl: command-driven sequencer in front of the multi-image CAM.
// Accepts write-image / search-image commands and a pixel stream. It drives the
// CAM write, search and address ports. During a search it ANDs the per-pixel
// match vector into a whole-image "found" result, one bit per image slot.
// Optional feature macro: CAM_MISMATCH_CNT_EN adds per-slot mismatch counters
// on output mismatch_cnt.
module cam_img_seq_ctrl #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 24,
   parameter int NO_OF_IMG  = 2,
   parameter int MATCH_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_op,
   input  logic [NO_OF_IMG-1:0]  cmd_slot,
   input  logic [ADDR_WIDTH-1:0] cmd_len,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [DATA_WIDTH-1:0] pix_data,
   output logic [NO_OF_IMG-1:0]  cam_we,
   output logic                  cam_match_en,
   output logic [ADDR_WIDTH-1:0] cam_addr,
   output logic [DATA_WIDTH-1:0] cam_din,
   output logic [ADDR_WIDTH-1:0] cam_size,
   input  logic [NO_OF_IMG-1:0]  cam_match,
   output logic                  busy,
   output logic                  done,
   output logic [NO_OF_IMG-1:0]  found
`ifdef CAM_MISMATCH_CNT_EN
   ,
   output logic [NO_OF_IMG*ADDR_WIDTH-1:0] mismatch_cnt
`endif
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WRITE  = 3'd1;
   localparam logic [2:0] ST_SEARCH = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [NO_OF_IMG-1:0]  IMG_ONE  = NO_OF_IMG'(1);

   // A slot vector selects exactly one image; anything else suppresses writes.
   function automatic logic is_onehot(input logic [NO_OF_IMG-1:0] v);
      return (v != '0) && ((v & (v - IMG_ONE)) == '0);
   endfunction

   logic [2:0]            state_q,        state_d;
   logic [NO_OF_IMG-1:0]  slot_q,         slot_d;
   logic [ADDR_WIDTH-1:0] len_q,          len_d;
   logic [ADDR_WIDTH-1:0] addr_q,         addr_d;
   logic [NO_OF_IMG-1:0]  acc_q,          acc_d;
   logic [MATCH_LAT-1:0]  pipe_q,         pipe_d;
   logic [NO_OF_IMG-1:0]  cam_we_q,       cam_we_d;
   logic                  cam_match_en_q, cam_match_en_d;
   logic [ADDR_WIDTH-1:0] cam_addr_q,     cam_addr_d;
   logic [DATA_WIDTH-1:0] cam_din_q,      cam_din_d;
   logic [ADDR_WIDTH-1:0] cam_size_q,     cam_size_d;
   logic                  done_q,         done_d;
   logic [NO_OF_IMG-1:0]  found_q,        found_d;
`ifdef CAM_MISMATCH_CNT_EN
   logic [NO_OF_IMG*ADDR_WIDTH-1:0] mm_cnt_q, mm_cnt_d;
`endif

   logic                  pix_fire_s;
   logic                  last_beat_s;
   logic                  tag_out_s;
   logic                  inflight_s;
   logic [NO_OF_IMG-1:0]  acc_upd_s;

   // Status decode straight from the state register.
   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      pix_ready = (state_q == ST_WRITE) || (state_q == ST_SEARCH);
   end

   assign cam_we       = cam_we_q;
   assign cam_match_en = cam_match_en_q;
   assign cam_addr     = cam_addr_q;
   assign cam_din      = cam_din_q;
   assign cam_size     = cam_size_q;
   assign done         = done_q;
   assign found        = found_q;
`ifdef CAM_MISMATCH_CNT_EN
   assign mismatch_cnt = mm_cnt_q;
`endif

   // Match-tag pipe: a tag enters with the search strobe and exits when cam_match is valid.
   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = cam_match_en_q;
      for (int i = 1; i < MATCH_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      tag_out_s  = pipe_q[MATCH_LAT-1];
      // Only the exiting stage may still be busy when DRAIN finishes; it is folded in below.
      inflight_s = cam_match_en_q;
      for (int i = 0; i < MATCH_LAT - 1; i++) begin
         inflight_s = inflight_s | pipe_q[i];
      end
      if (tag_out_s) begin
         acc_upd_s = acc_q & cam_match;
      end else begin
         acc_upd_s = acc_q;
      end
   end

   // Sequencer next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      slot_d         = slot_q;
      len_d          = len_q;
      addr_d         = addr_q;
      acc_d          = acc_upd_s;
      cam_we_d       = '0;
      cam_match_en_d = 1'b0;
      cam_addr_d     = cam_addr_q;
      cam_din_d      = cam_din_q;
      cam_size_d     = cam_size_q;
      done_d         = 1'b0;
      found_d        = found_q;
      pix_fire_s     = pix_valid && pix_ready;
      last_beat_s    = (addr_q == (len_q - ADDR_ONE));

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               slot_d     = cmd_slot;
               len_d      = cmd_len;
               cam_size_d = cmd_len;
               addr_d     = '0;
               acc_d      = '1;
               found_d    = '0;
               if (cmd_len == '0) begin
                  // Empty image: nothing to stream, report "not found" right away.
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (cmd_op) begin
                  state_d = ST_SEARCH;
               end else begin
                  state_d = ST_WRITE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (pix_fire_s) begin
               if (is_onehot(slot_q)) begin
                  cam_we_d = slot_q;
               end else begin
                  cam_we_d = '0;
               end
               cam_din_d  = pix_data;
               cam_addr_d = addr_q;
               addr_d     = addr_q + ADDR_ONE;
               if (last_beat_s) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  found_d = '0;
               end else begin
                  state_d = ST_WRITE;
               end
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_SEARCH: begin
            if (pix_fire_s) begin
               cam_match_en_d = 1'b1;
               cam_din_d      = pix_data;
               cam_addr_d     = addr_q;
               addr_d         = addr_q + ADDR_ONE;
               if (last_beat_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_SEARCH;
               end
            end else begin
               state_d = ST_SEARCH;
            end
         end
         ST_DRAIN: begin
            if (!inflight_s) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               found_d = acc_upd_s;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef CAM_MISMATCH_CNT_EN
   // Per-slot count of searched pixels that missed; saturates instead of wrapping.
   always_comb begin
      mm_cnt_d = mm_cnt_q;
      if ((state_q == ST_IDLE) && cmd_valid && cmd_op) begin
         mm_cnt_d = '0;
      end else if (tag_out_s) begin
         for (int i = 0; i < NO_OF_IMG; i++) begin
            if (!cam_match[i] && (mm_cnt_q[i*ADDR_WIDTH +: ADDR_WIDTH] != '1)) begin
               mm_cnt_d[i*ADDR_WIDTH +: ADDR_WIDTH] = mm_cnt_q[i*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_ONE;
            end else begin
               mm_cnt_d[i*ADDR_WIDTH +: ADDR_WIDTH] = mm_cnt_q[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
         end
      end else begin
         mm_cnt_d = mm_cnt_q;
      end
   end

   // Mismatch counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mm_cnt_q <= '0;
      end else begin
         mm_cnt_q <= mm_cnt_d;
      end
   end
`endif

   // State and output registers; CAM contents live outside and survive reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         slot_q         <= '0;
         len_q          <= '0;
         addr_q         <= '0;
         acc_q          <= '1;
         pipe_q         <= '0;
         cam_we_q       <= '0;
         cam_match_en_q <= 1'b0;
         cam_addr_q     <= '0;
         cam_din_q      <= '0;
         cam_size_q     <= '0;
         done_q         <= 1'b0;
         found_q        <= '0;
      end else begin
         state_q        <= state_d;
         slot_q         <= slot_d;
         len_q          <= len_d;
         addr_q         <= addr_d;
         acc_q          <= acc_d;
         pipe_q         <= pipe_d;
         cam_we_q       <= cam_we_d;
         cam_match_en_q <= cam_match_en_d;
         cam_addr_q     <= cam_addr_d;
         cam_din_q      <= cam_din_d;
         cam_size_q     <= cam_size_d;
         done_q         <= done_d;
         found_q        <= found_d;
      end
   end

endmodule
